fsic_io_deserdes_rx: RTL and testbench

//  Receive end of the FSIC serial link: one-clock deframer for the 12-lane stream the io_serdes TX path drives.

---
 rtl/fsic_serdes_pkg.sv | 56 +++++
 rtl/fsic_rx_sync_fifo.sv | 76 +++++++
 rtl/fsic_io_deserdes_rx.sv | 188 ++++++++++++++++++
 tb/tb_fsic_io_deserdes_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsic_serdes_pkg.sv
// rtl/fsic_serdes_pkg.sv - shared lane map, FSM states and beat layout for the FSIC serial RX path
package fsic_serdes_pkg;

    // serial lane positions
    localparam int FC_LANE    = 11;
    localparam int TIDU_LANE  = 10;
    localparam int TKEEP_LANE = 9;
    localparam int TSTRB_LANE = 8;

    // flow-control lane bit carried at each phase
    localparam int FC_TREADY = 0;
    localparam int FC_TVALID = 1;
    localparam int FC_TLAST  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [31:0] tdata;
        logic [3:0]  tstrb;
        logic [3:0]  tkeep;
        logic [1:0]  tid;
        logic [1:0]  tuser;
        logic        tlast;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    // Rebuild a beat from per-phase shadow samples: data lane j at phase p is tdata bit 4j+p,
    // and the tid/tuser lane carries bit p of {tid,tuser}.
    function automatic beat_t assemble_beat(
        input logic [3:0][7:0] data,
        input logic [3:0]      strb,
        input logic [3:0]      keep,
        input logic [3:0]      tidu,
        input logic            tlast
    );
        beat_t b;
        b.tdata = '0;
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 8; j++) begin
                b.tdata[5'(4 * j + p)] = data[2'(p)][3'(j)];
            end
        end
        b.tstrb = strb;
        b.tkeep = keep;
        b.tid   = tidu[3:2];
        b.tuser = tidu[1:0];
        b.tlast = tlast;
        return b;
    endfunction

endpackage

// File: rtl/fsic_rx_sync_fifo.sv
// rtl/fsic_rx_sync_fifo.sv - single-clock beat FIFO with any depth >= 2 and a synchronous flush
module fsic_rx_sync_fifo #(
    parameter int WIDTH = 45,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so a non-power-of-two depth works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; flush discards everything queued.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fsic_io_deserdes_rx.sv
// rtl/fsic_io_deserdes_rx.sv - FSIC 12-lane deframer to AXIS master; FSIC_RX_OVF_CNT_EN adds rx_ovf_cnt
module fsic_io_deserdes_rx
    import fsic_serdes_pkg::*;
#(
    parameter int pSERIALIO_WIDTH = 12,
    parameter int pDATA_WIDTH     = 32,
    parameter int pCLK_RATIO      = 4,
    parameter int pRxFIFO_DEPTH   = 5
) (
    input  logic                       ioclk,
    input  logic                       axis_rst,
    input  logic                       rxen,
    input  logic [pSERIALIO_WIDTH-1:0] serial_rxd,
    output logic [pDATA_WIDTH-1:0]     is_as_tdata,
    output logic [3:0]                 is_as_tstrb,
    output logic [3:0]                 is_as_tkeep,
    output logic [1:0]                 is_as_tid,
    output logic [1:0]                 is_as_tuser,
    output logic                       is_as_tlast,
    output logic                       is_as_tvalid,
    input  logic                       is_as_tready,
    output logic                       remote_tready,
    output logic                       rx_locked,
    output logic                       rx_overflow
`ifdef FSIC_RX_OVF_CNT_EN
    ,
    output logic [15:0]                rx_ovf_cnt
`endif
);
    localparam logic [1:0] LAST_PHASE = 2'(pCLK_RATIO - 1);

    rx_state_e       state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [3:0][7:0] data_sh_q, data_sh_d;
    logic [3:0]      strb_sh_q, strb_sh_d;
    logic [3:0]      keep_sh_q, keep_sh_d;
    logic [3:0]      tidu_sh_q, tidu_sh_d;
    logic [2:0]      fc_sh_q, fc_sh_d;
    beat_t           beat_q, beat_d;
    logic            push_q, push_d;
    logic            remote_tready_q, remote_tready_d;
    logic            rx_locked_q, rx_locked_d;
    logic            rx_overflow_q, rx_overflow_d;

    logic            flush, capture, frame_end, pop, drop;
    logic            fifo_full, fifo_empty;
    beat_t           head;

    assign flush     = !rxen;
    assign capture   = rxen && ((state_q == HUNT && serial_rxd[FC_LANE]) || state_q == LOCKED);
    assign frame_end = rxen && (state_q == LOCKED) && (phase_q == LAST_PHASE);
    assign pop       = is_as_tvalid && is_as_tready;
    assign drop      = push_q && fifo_full && !pop && !flush;

    // Deframer next-state: lock on the first fc=1 sample, shadow each phase, register the beat at phase 3.
    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        data_sh_d       = data_sh_q;
        strb_sh_d       = strb_sh_q;
        keep_sh_d       = keep_sh_q;
        tidu_sh_d       = tidu_sh_q;
        fc_sh_d         = fc_sh_q;
        beat_d          = beat_q;
        push_d          = 1'b0;
        remote_tready_d = remote_tready_q;
        rx_overflow_d   = rx_overflow_q | drop;

        if (!rxen) begin
            state_d = IDLE;
            phase_d = 2'd0;
        end else begin
            case (state_q)
                IDLE:    state_d = HUNT;
                HUNT: begin
                    if (serial_rxd[FC_LANE]) begin
                        state_d = LOCKED;
                        phase_d = 2'd1;
                    end
                end
                LOCKED:  phase_d = (phase_q == LAST_PHASE) ? 2'd0 : phase_q + 2'd1;
                default: state_d = IDLE;
            endcase
        end

        if (capture) begin
            data_sh_d[phase_q] = serial_rxd[TSTRB_LANE-1:0];
            strb_sh_d[phase_q] = serial_rxd[TSTRB_LANE];
            keep_sh_d[phase_q] = serial_rxd[TKEEP_LANE];
            tidu_sh_d[phase_q] = serial_rxd[TIDU_LANE];
            case (phase_q)
                2'd0:    fc_sh_d[FC_TREADY] = serial_rxd[FC_LANE];
                2'd1:    fc_sh_d[FC_TVALID] = serial_rxd[FC_LANE];
                2'd2:    fc_sh_d[FC_TLAST]  = serial_rxd[FC_LANE];
                default: ;
            endcase
        end

        if (frame_end) begin
            beat_d          = assemble_beat(data_sh_d, strb_sh_d, keep_sh_d, tidu_sh_d, fc_sh_d[FC_TLAST]);
            push_d          = fc_sh_d[FC_TVALID];
            remote_tready_d = fc_sh_d[FC_TREADY];
        end

        rx_locked_d = (state_d == LOCKED);
    end

    // Deframer FSM, shadow registers and registered status outputs.
    always_ff @(posedge ioclk) begin
        if (axis_rst) begin
            state_q         <= IDLE;
            phase_q         <= 2'd0;
            data_sh_q       <= '0;
            strb_sh_q       <= '0;
            keep_sh_q       <= '0;
            tidu_sh_q       <= '0;
            fc_sh_q         <= '0;
            beat_q          <= '0;
            push_q          <= 1'b0;
            remote_tready_q <= 1'b0;
            rx_locked_q     <= 1'b0;
            rx_overflow_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            data_sh_q       <= data_sh_d;
            strb_sh_q       <= strb_sh_d;
            keep_sh_q       <= keep_sh_d;
            tidu_sh_q       <= tidu_sh_d;
            fc_sh_q         <= fc_sh_d;
            beat_q          <= beat_d;
            push_q          <= push_d;
            remote_tready_q <= remote_tready_d;
            rx_locked_q     <= rx_locked_d;
            rx_overflow_q   <= rx_overflow_d;
        end
    end

    fsic_rx_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (pRxFIFO_DEPTH)
    ) u_fifo (
        .clk       (ioclk),
        .rst       (axis_rst),
        .flush     (flush),
        .push      (push_q),
        .push_data (beat_q),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign is_as_tdata   = head.tdata;
    assign is_as_tstrb   = head.tstrb;
    assign is_as_tkeep   = head.tkeep;
    assign is_as_tid     = head.tid;
    assign is_as_tuser   = head.tuser;
    assign is_as_tlast   = head.tlast;
    assign is_as_tvalid  = !fifo_empty;
    assign remote_tready = remote_tready_q;
    assign rx_locked     = rx_locked_q;
    assign rx_overflow   = rx_overflow_q;

`ifdef FSIC_RX_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Dropped-beat counter, saturating at all ones.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge ioclk) begin
        if (axis_rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign rx_ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_fsic_io_deserdes_rx.sv
// tb/tb_fsic_io_deserdes_rx.sv - scoreboard bench for fsic_io_deserdes_rx
module tb_fsic_io_deserdes_rx;
    import fsic_serdes_pkg::*;

    localparam int DEPTH = 5;

    logic        clk = 1'b0;
    logic        axis_rst;
    logic        rxen;
    logic [11:0] serial_rxd;
    logic [31:0] is_as_tdata;
    logic [3:0]  is_as_tstrb;
    logic [3:0]  is_as_tkeep;
    logic [1:0]  is_as_tid;
    logic [1:0]  is_as_tuser;
    logic        is_as_tlast;
    logic        is_as_tvalid;
    logic        is_as_tready;
    logic        remote_tready;
    logic        rx_locked;
    logic        rx_overflow;
`ifdef FSIC_RX_OVF_CNT_EN
    logic [15:0] rx_ovf_cnt;
`endif

    fsic_io_deserdes_rx #(
        .pSERIALIO_WIDTH (12),
        .pDATA_WIDTH     (32),
        .pCLK_RATIO      (4),
        .pRxFIFO_DEPTH   (DEPTH)
    ) dut (
        .ioclk         (clk),
        .axis_rst      (axis_rst),
        .rxen          (rxen),
        .serial_rxd    (serial_rxd),
        .is_as_tdata   (is_as_tdata),
        .is_as_tstrb   (is_as_tstrb),
        .is_as_tkeep   (is_as_tkeep),
        .is_as_tid     (is_as_tid),
        .is_as_tuser   (is_as_tuser),
        .is_as_tlast   (is_as_tlast),
        .is_as_tvalid  (is_as_tvalid),
        .is_as_tready  (is_as_tready),
        .remote_tready (remote_tready),
        .rx_locked     (rx_locked),
        .rx_overflow   (rx_overflow)
`ifdef FSIC_RX_OVF_CNT_EN
        ,
        .rx_ovf_cnt    (rx_ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    due;
        beat_t b;
    } push_ev_t;

    typedef struct {
        int   due;
        logic v;
    } rem_ev_t;

    // Reference model state: queued beats, events due at the end of a given cycle, sticky flags.
    beat_t    exp_q[$];
    push_ev_t push_ev[$];
    rem_ev_t  rem_ev[$];
    logic     exp_remote = 1'b0;
    logic     exp_ovf    = 1'b0;
    int       exp_ovf_cnt = 0;
    bit       mon_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane value for phase p of a frame, straight from the lane map.
    function automatic logic [11:0] encode(input beat_t b, input logic vld, input logic rdy, input int p);
        logic [11:0] s;
        logic [3:0]  tidu;
        tidu = {b.tid, b.tuser};
        for (int j = 0; j < 8; j++) s[j] = b.tdata[4 * j + p];
        s[8]  = b.tstrb[p];
        s[9]  = b.tkeep[p];
        s[10] = tidu[p];
        case (p)
            0:       s[11] = rdy;
            1:       s[11] = vld;
            2:       s[11] = b.tlast;
            default: s[11] = 1'($urandom_range(0, 1));
        endcase
        return s;
    endfunction

    function automatic beat_t rand_beat();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[44:0];
    endfunction

    // Drive one 4-cycle frame; pop_mask[p] is the local sink ready during phase p.
    task automatic send_frame(input beat_t b, input logic vld, input logic rdy, input logic [3:0] pop_mask);
        for (int p = 0; p < 4; p++) begin
            serial_rxd   = encode(b, vld, rdy, p);
            is_as_tready = pop_mask[p];
            if (p == 3) begin
                rem_ev.push_back('{cyc, rdy});
                if (vld) push_ev.push_back('{cyc + 1, b});
            end
            step();
        end
    endtask

    // Monitor: compare DUT against model state, then advance the model by this cycle's events.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("tvalid", 64'(is_as_tvalid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("beat", 64'({is_as_tdata, is_as_tstrb, is_as_tkeep, is_as_tid, is_as_tuser, is_as_tlast}),
                    64'(exp_q[0]));
            end
            chk("remote_tready", 64'(remote_tready), 64'(exp_remote));
            chk("rx_overflow", 64'(rx_overflow), 64'(exp_ovf));
`ifdef FSIC_RX_OVF_CNT_EN
            chk("rx_ovf_cnt", 64'(rx_ovf_cnt), 64'(exp_ovf_cnt));
`endif
            if (exp_q.size() != 0 && is_as_tready) void'(exp_q.pop_front());
            if (!rxen) begin
                exp_q.delete();
                push_ev.delete();
            end else begin
                while (push_ev.size() != 0 && push_ev[0].due == cyc) begin
                    if (exp_q.size() < DEPTH) begin
                        exp_q.push_back(push_ev[0].b);
                    end else begin
                        exp_ovf = 1'b1;
                        if (exp_ovf_cnt < 65535) exp_ovf_cnt++;
                    end
                    void'(push_ev.pop_front());
                end
            end
            while (rem_ev.size() != 0 && rem_ev[0].due == cyc) begin
                exp_remote = rem_ev[0].v;
                void'(rem_ev.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        axis_rst     = 1'b1;
        rxen         = 1'b0;
        serial_rxd   = '0;
        is_as_tready = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_tvalid", 64'(is_as_tvalid), 64'd0);
        chk("rst_locked", 64'(rx_locked), 64'd0);
        chk("rst_remote", 64'(remote_tready), 64'd0);
        chk("rst_ovf", 64'(rx_overflow), 64'd0);
        chk("rst_tdata", 64'(is_as_tdata), 64'd0);
        axis_rst = 1'b0;
        mon_en   = 1'b1;

        // 1: enabled with idle lanes never locks
        rxen = 1'b1;
        repeat (10) step();
        chk("idle_locked", 64'(rx_locked), 64'd0);

        // 2: one known frame with sink ready
        b.tdata = 32'h89AB_CDEF; b.tstrb = 4'hF; b.tkeep = 4'hF;
        b.tid = 2'd2; b.tuser = 2'd1; b.tlast = 1'b1;
        send_frame(b, 1'b1, 1'b1, 4'hF);
        chk("lock_after_frame", 64'(rx_locked), 64'd1);
        chk("remote_after_frame", 64'(remote_tready), 64'd1);
        repeat (2) send_frame(rand_beat(), 1'b0, 1'b1, 4'hF);

        // 3: six valid frames into a blocked sink, sixth dropped
        for (int i = 0; i < 6; i++) send_frame(rand_beat(), 1'b1, 1'b1, 4'h0);
        send_frame(rand_beat(), 1'b0, 1'b1, 4'h0);
        chk("ovf_set", 64'(rx_overflow), 64'd1);
`ifdef FSIC_RX_OVF_CNT_EN
        chk("ovf_cnt_one", 64'(rx_ovf_cnt), 64'd1);
`endif

        // 6: full FIFO, push coincides with a pop
        send_frame(rand_beat(), 1'b1, 1'b1, 4'h0);
        send_frame(rand_beat(), 1'b0, 1'b1, 4'b0001);
        send_frame(rand_beat(), 1'b0, 1'b1, 4'h0);
`ifdef FSIC_RX_OVF_CNT_EN
        chk("ovf_cnt_no_drop", 64'(rx_ovf_cnt), 64'd1);
`endif
        repeat (3) send_frame(rand_beat(), 1'b0, 1'b1, 4'hF);

        // 4: tvalid=0, tready=0 frame
        send_frame(rand_beat(), 1'b0, 1'b0, 4'hF);
        chk("remote_low", 64'(remote_tready), 64'd0);
        chk("nothing_pushed", 64'(is_as_tvalid), 64'd0);

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            send_frame(rand_beat(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)));
        end
        repeat (3) send_frame(rand_beat(), 1'b0, 1'b1, 4'hF);

        // 5: drop rxen at phase 2 with three beats queued, then relock
        for (int i = 0; i < 3; i++) send_frame(rand_beat(), 1'b1, 1'b1, 4'h0);
        b = rand_beat();
        serial_rxd = encode(b, 1'b0, 1'b1, 0);
        step();
        serial_rxd = encode(b, 1'b0, 1'b1, 1);
        step();
        chk("three_queued", 64'(exp_q.size()), 64'd3);
        serial_rxd = encode(b, 1'b0, 1'b1, 2);
        rxen = 1'b0;
        step();
        chk("disable_tvalid", 64'(is_as_tvalid), 64'd0);
        chk("disable_locked", 64'(rx_locked), 64'd0);
        rxen       = 1'b1;
        serial_rxd = '0;
        repeat (3) step();
        chk("rehunt_unlocked", 64'(rx_locked), 64'd0);
        send_frame(rand_beat(), 1'b1, 1'b1, 4'hF);
        chk("relocked", 64'(rx_locked), 64'd1);
        repeat (2) send_frame(rand_beat(), 1'b0, 1'b1, 4'hF);

        chk("drained", 64'(exp_q.size() + push_ev.size()), 64'd0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
